// File: rtl/uart_cmd_pkg.sv
// Shared constants and encodings for the UART register-write command sequencer.
package uart_cmd_pkg;

  localparam logic [7:0]  SYNC_BYTE = 8'h55;
  localparam int unsigned FRAME_LEN = 5;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StAddr   = 3'd1,
    StDhi    = 3'd2,
    StDlo    = 3'd3,
    StCksum  = 3'd4,
    StCommit = 3'd5
  } cmd_state_e;

  // Byte position of each field within a command frame.
  typedef enum logic [2:0] {
    FieldSync   = 3'd0,
    FieldAddr   = 3'd1,
    FieldDataHi = 3'd2,
    FieldDataLo = 3'd3,
    FieldCksum  = 3'(FRAME_LEN - 1)
  } cmd_field_e;

  // States in which the frame is still collecting bytes and the gap timer runs.
  function automatic logic in_frame(cmd_state_e s);
    return s inside {StAddr, StDhi, StDlo, StCksum};
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap counter: counts enabled, uncleared clocks and pulses on the terminal count.
module uart_gap_timer (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        enable_i,
  input  logic        clear_i,
  input  logic [15:0] terminal_i,
  output logic        expire_o
);

  logic [15:0] cnt_q, cnt_d;

  // A clear in the terminal cycle suppresses the pulse, so an arriving byte wins.
  assign expire_o = enable_i && !clear_i && (cnt_q == terminal_i - 16'd1);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clear_i || !enable_i || expire_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frames the UART byte stream into SYNC/ADDR/DATA_HI/DATA_LO/CKSUM register writes,
// with gap-timeout and checksum error detection and a saturating error counter.
module uart_cmd_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 234,
  parameter int unsigned GAP_BYTES    = 4,
  parameter int unsigned TIMEOUT_CLKS = CLKS_PER_BIT * 10 * GAP_BYTES
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  input  logic        i_Rx_Active,
  output logic        o_Wr_En,
  output logic [7:0]  o_Wr_Addr,
  output logic [15:0] o_Wr_Data,
  output logic        o_Busy,
  output logic        o_Err_Cksum,
  output logic        o_Err_Timeout,
  output logic [7:0]  o_Err_Count
);
  import uart_cmd_pkg::*;

  cmd_state_e  state_q, state_d;
  logic [7:0]  addr_sh_q, addr_sh_d;
  logic [15:0] data_sh_q, data_sh_d;
  logic [7:0]  sum_q, sum_d;
  logic        wr_en_q, busy_q, err_cksum_q;
  logic [7:0]  wr_addr_q, err_cnt_q;
  logic [15:0] wr_data_q;
  logic        cksum_err, commit;
  logic        timer_en, timer_clr, timer_expire;

  assign timer_en  = in_frame(state_q);
  assign timer_clr = i_Rx_DV | i_Rx_Active | ~timer_en;

  uart_gap_timer u_gap_timer (
    .i_Clock    (i_Clock),
    .i_Reset_n  (i_Reset_n),
    .enable_i   (timer_en),
    .clear_i    (timer_clr),
    .terminal_i (16'(TIMEOUT_CLKS)),
    .expire_o   (timer_expire)
  );

  always_comb begin
    state_d   = state_q;
    addr_sh_d = addr_sh_q;
    data_sh_d = data_sh_q;
    sum_d     = sum_q;
    cksum_err = 1'b0;
    commit    = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) state_d = StAddr;
      end
      StAddr: begin
        if (i_Rx_DV) begin
          addr_sh_d = i_Rx_Byte;
          sum_d     = i_Rx_Byte;
          state_d   = StDhi;
        end
      end
      StDhi: begin
        if (i_Rx_DV) begin
          data_sh_d[15:8] = i_Rx_Byte;
          sum_d           = sum_q + i_Rx_Byte;
          state_d         = StDlo;
        end
      end
      StDlo: begin
        if (i_Rx_DV) begin
          data_sh_d[7:0] = i_Rx_Byte;
          sum_d          = sum_q + i_Rx_Byte;
          state_d        = StCksum;
        end
      end
      StCksum: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == sum_q) begin
            state_d = StCommit;
          end else begin
            cksum_err = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      StCommit: begin
        commit  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Expiry only fires without a DV, so it never overrides a byte being taken.
    if (timer_expire) state_d = StIdle;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q     <= StIdle;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      sum_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      err_cksum_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      sum_q       <= sum_d;
      wr_en_q     <= commit;
      busy_q      <= (state_d != StIdle);
      err_cksum_q <= cksum_err;
      if (commit) begin
        wr_addr_q <= addr_sh_q;
        wr_data_q <= data_sh_q;
      end
      if ((cksum_err || timer_expire) && err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign o_Wr_En       = wr_en_q;
  assign o_Wr_Addr     = wr_addr_q;
  assign o_Wr_Data     = wr_data_q;
  assign o_Busy        = busy_q;
  assign o_Err_Cksum   = err_cksum_q;
  assign o_Err_Timeout = timer_expire;
  assign o_Err_Count   = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: frame-level reference model plus directed tests.
module tb_uart_cmd_ctrl;

  localparam int TMO = 234 * 10 * 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        rx_active;
  logic        o_Wr_En;
  logic [7:0]  o_Wr_Addr;
  logic [15:0] o_Wr_Data;
  logic        o_Busy;
  logic        o_Err_Cksum;
  logic        o_Err_Timeout;
  logic [7:0]  o_Err_Count;

  uart_cmd_ctrl dut (
    .i_Clock       (clk),
    .i_Reset_n     (rst_n),
    .i_Rx_DV       (rx_dv),
    .i_Rx_Byte     (rx_byte),
    .i_Rx_Active   (rx_active),
    .o_Wr_En       (o_Wr_En),
    .o_Wr_Addr     (o_Wr_Addr),
    .o_Wr_Data     (o_Wr_Data),
    .o_Busy        (o_Busy),
    .o_Err_Cksum   (o_Err_Cksum),
    .o_Err_Timeout (o_Err_Timeout),
    .o_Err_Count   (o_Err_Count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0;
  int cksum_pulses = 0;
  int tmo_pulses = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference model: collects frame bytes in a queue and predicts outputs per cycle.
  logic [7:0]  m_frm[$];
  bit          m_commit;
  int          m_gap;
  logic        m_wr_en, m_busy, m_cksum;
  logic [7:0]  m_addr, m_cnt, m_sum, p_addr;
  logic [15:0] m_data, p_data;

  task automatic model_reset();
    m_frm.delete();
    m_commit = 0; m_gap = 0;
    m_wr_en = 0; m_busy = 0; m_cksum = 0;
    m_addr = 0; m_cnt = 0; m_data = 0; p_addr = 0; p_data = 0;
  endtask

  task automatic bump();
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
  endtask

  task automatic model_step();
    m_wr_en = 0;
    m_cksum = 0;
    if (m_commit) begin
      m_wr_en = 1; m_addr = p_addr; m_data = p_data;
      m_commit = 0; m_gap = 0;
    end else if (m_frm.size() == 0) begin
      if (rx_dv && rx_byte == 8'h55) m_frm.push_back(rx_byte);
      m_gap = 0;
    end else if (rx_dv) begin
      m_frm.push_back(rx_byte);
      m_gap = 0;
      if (m_frm.size() == 5) begin
        m_sum = m_frm[1] + m_frm[2] + m_frm[3];
        if (m_sum == m_frm[4]) begin
          m_commit = 1; p_addr = m_frm[1]; p_data = {m_frm[2], m_frm[3]};
        end else begin
          m_cksum = 1; bump();
        end
        m_frm.delete();
      end
    end else if (!rx_active && m_gap == TMO - 1) begin
      bump(); m_frm.delete(); m_gap = 0;
    end else if (rx_active) begin
      m_gap = 0;
    end else begin
      m_gap++;
    end
    m_busy = (m_frm.size() > 0) || m_commit;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison and pulse monitors, sampled mid-cycle.
  logic exp_to;
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      exp_to = (m_frm.size() > 0) && !rx_dv && !rx_active && (m_gap == TMO - 1);
      chk("cycle {wr,addr,data,busy,ck,to,cnt}",
          64'({o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Busy, o_Err_Cksum, o_Err_Timeout, o_Err_Count}),
          64'({m_wr_en, m_addr, m_data, m_busy, m_cksum, exp_to, m_cnt}));
      if (o_Wr_En) wr_pulses++;
      if (o_Err_Cksum) cksum_pulses++;
      if (o_Err_Timeout) tmo_pulses++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_dv = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    rx_dv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = 4; i >= 0; i--) send_byte(f[i*8 +: 8]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int w0, c0, t0, k;

  initial begin
    rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; rx_active = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("reset wr_en", 64'(o_Wr_En), 64'd0);
    chk("reset addr", 64'(o_Wr_Addr), 64'd0);
    chk("reset data", 64'(o_Wr_Data), 64'd0);
    chk("reset busy", 64'(o_Busy), 64'd0);
    chk("reset count", 64'(o_Err_Count), 64'd0);

    // Good frame
    w0 = wr_pulses; c0 = cksum_pulses;
    send_frame(40'h55_12_BE_EF_BF);
    chk("good wr pulses", 64'(wr_pulses - w0), 64'd1);
    chk("good addr", 64'(o_Wr_Addr), 64'h12);
    chk("good data", 64'(o_Wr_Data), 64'hBEEF);
    chk("good cksum pulses", 64'(cksum_pulses - c0), 64'd0);
    chk("good count", 64'(o_Err_Count), 64'd0);
    chk("model addr", 64'(m_addr), 64'h12);
    chk("model data", 64'(m_data), 64'hBEEF);

    // Bad checksum then good frame
    w0 = wr_pulses; c0 = cksum_pulses;
    send_frame(40'h55_12_BE_EF_C0);
    chk("bad cksum pulses", 64'(cksum_pulses - c0), 64'd1);
    chk("bad wr pulses", 64'(wr_pulses - w0), 64'd0);
    chk("bad addr held", 64'(o_Wr_Addr), 64'h12);
    chk("bad data held", 64'(o_Wr_Data), 64'hBEEF);
    chk("bad count", 64'(o_Err_Count), 64'd1);
    chk("model count", 64'(m_cnt), 64'd1);
    send_frame(40'h55_01_00_02_03);
    chk("after-bad addr", 64'(o_Wr_Addr), 64'h01);
    chk("after-bad data", 64'(o_Wr_Data), 64'h0002);

    // Noise in idle
    do_reset();
    w0 = wr_pulses;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'hAA);
    chk("noise busy", 64'(o_Busy), 64'd0);
    send_frame(40'h55_20_00_01_21);
    chk("noise wr pulses", 64'(wr_pulses - w0), 64'd1);
    chk("noise addr", 64'(o_Wr_Addr), 64'h20);
    chk("noise data", 64'(o_Wr_Data), 64'h0001);
    chk("noise count", 64'(o_Err_Count), 64'd0);

    // Timeout: pulse exactly TMO-1 clocks after the DV edge
    do_reset();
    t0 = tmo_pulses; w0 = wr_pulses;
    send_byte(8'h55);
    rx_dv = 1'b1; rx_byte = 8'h12;
    @(posedge clk); #1 rx_dv = 1'b0;
    for (k = 1; k <= TMO + 5; k++) begin
      @(posedge clk); #1;
      if (o_Err_Timeout) break;
    end
    chk("timeout latency", 64'(k), 64'(TMO - 1));
    @(posedge clk); #1;
    chk("timeout busy", 64'(o_Busy), 64'd0);
    chk("timeout count", 64'(o_Err_Count), 64'd1);
    chk("timeout pulses", 64'(tmo_pulses - t0), 64'd1);
    send_byte(8'hBE); send_byte(8'hEF); send_byte(8'hBF);
    chk("timeout aborted", 64'(wr_pulses - w0), 64'd0);

    // Byte on the terminal cycle wins over the timeout
    do_reset();
    t0 = tmo_pulses; w0 = wr_pulses;
    send_byte(8'h55);
    rx_dv = 1'b1; rx_byte = 8'h12;
    @(posedge clk); #1 rx_dv = 1'b0;
    for (int i = 1; i <= TMO - 1; i++) @(posedge clk);
    #1;
    chk("terminal cycle reached", 64'(o_Err_Timeout), 64'd1);
    rx_dv = 1'b1; rx_byte = 8'hBE;
    #1;
    chk("terminal dv suppresses", 64'(o_Err_Timeout), 64'd0);
    @(posedge clk); #1 rx_dv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_byte(8'hEF); send_byte(8'hBF);
    chk("terminal wr pulses", 64'(wr_pulses - w0), 64'd1);
    chk("terminal data", 64'(o_Wr_Data), 64'hBEEF);
    chk("terminal count", 64'(o_Err_Count), 64'd0);
    chk("terminal tmo pulses", 64'(tmo_pulses - t0), 64'd0);

    // Asynchronous reset mid-frame
    send_byte(8'h55); send_byte(8'h12); send_byte(8'hBE);
    chk("pre-reset busy", 64'(o_Busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async busy", 64'(o_Busy), 64'd0);
    chk("async addr", 64'(o_Wr_Addr), 64'd0);
    chk("async data", 64'(o_Wr_Data), 64'd0);
    chk("async wr_en", 64'(o_Wr_En), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    w0 = wr_pulses;
    send_byte(8'h12); send_byte(8'hBE); send_byte(8'hEF); send_byte(8'hBF);
    chk("no-sync wr pulses", 64'(wr_pulses - w0), 64'd0);

    // Error counter saturation
    do_reset();
    c0 = cksum_pulses; w0 = wr_pulses;
    for (int i = 0; i < 260; i++) begin
      send_frame(40'h55_00_00_00_01);
      if (i == 254) chk("count at 255", 64'(o_Err_Count), 64'd255);
    end
    chk("saturated count", 64'(o_Err_Count), 64'd255);
    chk("saturation cksum pulses", 64'(cksum_pulses - c0), 64'd260);
    chk("saturation wr pulses", 64'(wr_pulses - w0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command sequencer behind the UART receiver in the DVI tester.
- Consumes the byte stream (data-valid pulse plus byte) and frames it into 5-byte register-write commands: SYNC, ADDR, DATA_HI, DATA_LO, CKSUM.
- Validates each frame and issues a single-cycle write strobe to the tester's configuration register bank.
- Detects inter-byte gaps (timeout) and checksum failures, and counts errors.

Parameters:
- CLKS_PER_BIT, 234, clocks per UART bit; same value as the receiver instance.
- GAP_BYTES, 4, allowed idle gap between bytes of one frame, in byte times.
- TIMEOUT_CLKS, CLKS_PER_BIT*10*GAP_BYTES (9360), clocks without a byte before a frame is aborted; legal range 2..65535.

Ports:
- i_Clock  in  1  system clock.
- i_Reset_n  in  1  asynchronous reset, active low.
- i_Rx_DV  in  1  one-cycle pulse: i_Rx_Byte is valid.
- i_Rx_Byte  in  8  received byte.
- i_Rx_Active  in  1  receiver is mid-byte; holds off the timeout.
- o_Wr_En  out  1  one-cycle register write strobe.
- o_Wr_Addr  out  8  register address; held between strobes.
- o_Wr_Data  out  16  register data {DATA_HI, DATA_LO}; held between strobes.
- o_Busy  out  1  a frame is in progress (state is not IDLE).
- o_Err_Cksum  out  1  one-cycle pulse: checksum mismatch.
- o_Err_Timeout  out  1  one-cycle pulse: gap timeout.
- o_Err_Count  out  8  total errors, saturating at 255.

Behaviour:
- Reset:
  - All outputs are 0 and the state is IDLE.
  - Reset is asynchronous, so asserting it mid-frame discards the frame immediately.
  - o_Wr_Addr, o_Wr_Data and o_Err_Count clear to 0.
- State encodings: IDLE, ADDR, DHI, DLO, CKSUM, COMMIT. Every transition is taken on a clock edge where i_Rx_DV=1, unless noted otherwise.
- IDLE:
  - Byte 0x55 (SYNC_BYTE) → ADDR.
  - Any other byte is ignored silently: no error, no count.
- ADDR: latch the byte into the shadow address and into the running sum → DHI.
- DHI: latch the byte into shadow data[15:8]; sum += byte → DLO.
- DLO: latch the byte into shadow data[7:0]; sum += byte → CKSUM.
- Sum arithmetic: 8-bit, modulo 256.
- CKSUM:
  - If the byte equals the sum → COMMIT.
  - Otherwise pulse o_Err_Cksum, increment the error count and go to IDLE.
  - The shadow registers are discarded; outputs keep their previous values.
- COMMIT: one cycle, entered unconditionally.
  - o_Wr_En=1; o_Wr_Addr and o_Wr_Data are updated from the shadow registers in the same cycle.
  - Then → IDLE.
- Latency: the CKSUM-byte DV is sampled at edge N. o_Wr_En is high during the cycle after edge N+1, with address and data already valid.
- Mid-frame bytes:
  - 0x55 received mid-frame is data; there is no resynchronisation.
  - A byte arriving in the COMMIT cycle is lost. This is legal because the receiver cannot deliver bytes back to back.
- Gap timer:
  - Active only in ADDR, DHI, DLO and CKSUM.
  - Cleared on i_Rx_DV, while i_Rx_Active=1, and in IDLE/COMMIT.
  - Otherwise increments each clock.
  - When it reaches TIMEOUT_CLKS-1: pulse o_Err_Timeout, increment the error count, go to IDLE.
- Simultaneous events:
  - Timeout terminal count in the same cycle as i_Rx_DV: the DV wins, the byte is processed and the timer clears.
  - Cksum error and timeout cannot coincide (exclusive states).
  - o_Err_Count increments by 1 per error event and holds at 255.
- o_Busy = (state != IDLE). It is registered as part of the state decode.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - SYNC_BYTE=8'h55 and FRAME_LEN=5;
  - the state encoding constants (3 bits);
  - the command-frame field order.
- One sub-module: uart_gap_timer, a 16-bit counter.
  - Inputs: enable, clear, terminal value.
  - Output: a one-cycle expire pulse.
  - Uses the same clock/reset.
- Remaining FSM, shadow registers and error counter live in uart_cmd_ctrl.

Test Plan:
- Good frame: bytes 55 12 BE EF BF → exactly one o_Wr_En pulse, o_Wr_Addr=0x12, o_Wr_Data=0xBEEF; no error pulses; o_Err_Count=0.
- Bad checksum: bytes 55 12 BE EF C0 → o_Err_Cksum pulse, no o_Wr_En, o_Wr_Addr/o_Wr_Data unchanged, o_Err_Count=1. A following good frame (55 01 00 02 03) writes 0x01/0x0002.
- Noise in IDLE: bytes 00 FF AA, then 55 20 00 01 21 → junk ignored, single write of 0x20/0x0001, o_Err_Count=0.
- Timeout: 55 12, then an idle line for TIMEOUT_CLKS clocks → o_Err_Timeout pulse exactly TIMEOUT_CLKS-1 clocks after the DV; o_Busy drops; the frame is aborted. A byte arriving on the terminal cycle instead is accepted, with no error.
- Reset mid-frame: pull i_Reset_n low after 55 12 BE → all outputs 0 asynchronously. After release, 12 BE EF BF (no SYNC) produces no write.
- Saturation: 260 bad-checksum frames → o_Err_Count reaches 255 and stays there; o_Err_Cksum pulses on every one.
